// File: rtl/row_packer.sv
// Packs 16-bit column indices into 64-bit row words (lane 0 in bits [15:0]) behind a DEPTH-entry output FIFO.
// Optional statistics outputs idx_count/row_count are built when ROW_PACKER_STATS_EN is defined.
module row_packer #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] PAD_VALUE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] idx_in,
  input  logic        idx_valid,
  input  logic        idx_last,
  input  logic        flush,
  output logic        idx_ready,
  output logic [63:0] row_out,
  output logic        row_last,
  output logic        row_valid,
`ifdef ROW_PACKER_STATS_EN
  output logic [31:0] idx_count,
  output logic [15:0] row_count,
`endif
  input  logic        row_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {EMPTY, FILLING} state_t;

  state_t          state_reg;
  logic [1:0]      lane_reg;
  logic [15:0]     stage_reg [4];

  logic [64:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [63:0]     row_out_reg;
  logic            row_last_reg;
  logic            row_valid_reg;

  logic            accept;
  logic            close_row;
  logic            flush_only;
  logic            push;
  logic            pop;
  logic            push_last;
  logic [63:0]     push_word;
  logic [AW-1:0]   rd_ptr_next;
  logic [AW-1:0]   wr_ptr_next;
  logic [CW-1:0]   count_next;
  logic [63:0]     head_word_next;
  logic            head_last_next;

  assign idx_ready  = (count_reg < CW'(DEPTH));
  assign accept     = idx_valid && idx_ready;
  assign close_row  = idx_last || flush;
  assign flush_only = flush && !idx_valid && idx_ready && (lane_reg != 2'd0);
  assign push       = (accept && ((lane_reg == 2'd3) || close_row)) || flush_only;
  assign pop        = row_valid_reg && row_ready;
  assign push_last  = accept ? close_row : 1'b1;

  // The pushed word is the staging lanes with the incoming index merged into its lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign push_word[gi*16 +: 16] =
        (accept && (lane_reg == 2'(gi))) ? idx_in : stage_reg[gi];

      always_ff @(posedge clk) begin
        if (reset || push) begin
          stage_reg[gi] <= PAD_VALUE;
        end else if (accept && (lane_reg == 2'(gi))) begin
          stage_reg[gi] <= idx_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
      lane_reg  <= 2'd0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept && !push) begin
            state_reg <= FILLING;
            lane_reg  <= 2'd1;
          end
        end
        FILLING: begin
          if (push) begin
            state_reg <= EMPTY;
            lane_reg  <= 2'd0;
          end else if (accept) begin
            lane_reg <= lane_reg + 2'd1;
          end
        end
        default: begin
          state_reg <= EMPTY;
          lane_reg  <= 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    count_next  = count_reg + CW'(push) - CW'(pop);
  end

  // Head is registered: a word pushed into a (possibly just-drained) FIFO bypasses the array read.
  always_comb begin
    head_word_next = 64'h0;
    head_last_next = 1'b0;
    if (count_next != '0) begin
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
        head_word_next = push_word;
        head_last_next = push_last;
      end else begin
        head_word_next = mem[rd_ptr_next][63:0];
        head_last_next = mem[rd_ptr_next][64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {push_last, push_word};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      row_out_reg   <= 64'h0;
      row_last_reg  <= 1'b0;
      row_valid_reg <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      row_out_reg   <= head_word_next;
      row_last_reg  <= head_last_next;
      row_valid_reg <= (count_next != '0);
    end
  end

  assign row_out   = row_out_reg;
  assign row_last  = row_last_reg;
  assign row_valid = row_valid_reg;

`ifdef ROW_PACKER_STATS_EN
  logic [31:0] idx_count_reg;
  logic [15:0] row_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_count_reg <= 32'h0;
      row_count_reg <= 16'h0;
    end else begin
      if (accept && (idx_count_reg != 32'hFFFF_FFFF)) begin
        idx_count_reg <= idx_count_reg + 32'd1;
      end
      if (push && push_last) begin
        row_count_reg <= row_count_reg + 16'd1;
      end
    end
  end

  assign idx_count = idx_count_reg;
  assign row_count = row_count_reg;
`endif

endmodule

// File: doc/row_packer.md
Name: row_packer

Overview:
- Packs a stream of 16-bit column indices into 64-bit row words, in the same format that bram_module consumes on its `row` input.
- Lets compare/intersection results and reordered index lists be written back to BRAM, or fed into another BRAM/PIC stage.
- Sits between an index producer (PIC-side logic) and a 64-bit row consumer.
- Contains a small output FIFO so producer and consumer are decoupled by a valid/ready handshake.

Parameters:
- DEPTH, 4, number of 64-bit words held in the output FIFO (power of two, >= 2).
- PAD_VALUE, 16'hFFFF, sentinel written into unused lanes of a partial final word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- idx_in  input  16  column index from producer.
- idx_valid  input  1  idx_in is valid this cycle.
- idx_last  input  1  idx_in is the final index of the current row; qualified by idx_valid.
- flush  input  1  close the current row without a new index; level-sampled.
- idx_ready  output  1  packer can accept an index or flush this cycle.
- row_out  output  64  packed row word at the FIFO head.
- row_last  output  1  row_out is the final word of a row.
- row_valid  output  1  row_out/row_last are valid.
- row_ready  input  1  consumer accepts the head word.

Behaviour:
- Reset (clk edge with reset=1) takes priority over all activity, including mid-row and a non-empty FIFO. After reset:
  - lane counter = 0; staging lanes = PAD_VALUE; FIFO empty; any partial row is discarded.
  - row_valid = 0, row_last = 0, row_out = 64'h0, idx_ready = 1.
- Lane order: the first index of a word goes in bits [15:0], the second in [31:16], the third in [47:32], the fourth in [63:48].
- Accept: an index is accepted when idx_valid && idx_ready. It is written into lane[lane counter], then:
  - if lane counter == 3 or idx_last = 1, push the completed word into the FIFO in the same cycle. Unused lanes hold PAD_VALUE. The pushed entry's last bit = idx_last. Lane counter returns to 0 and staging is reset to PAD_VALUE.
  - otherwise, increment the lane counter.
- Flush is evaluated only when idx_ready = 1:
  - flush && !idx_valid with lane counter > 0: push the padded partial word with last = 1, clear staging, lane counter = 0.
  - flush && !idx_valid with lane counter == 0: no operation; nothing is pushed.
  - flush && idx_valid: treated exactly as idx_last = 1 on that index.
  - Producer must hold flush until idx_ready = 1.
- idx_ready = (FIFO count < DEPTH). There is no pass-through when full: push and pop cannot combine to admit a push in a full cycle.
- FIFO:
  - row_valid = (count != 0).
  - row_out/row_last show the head entry; row_out = 0 and row_last = 0 when empty.
  - Pop when row_valid && row_ready.
  - Simultaneous push and pop with 0 < count < DEPTH keeps count unchanged.
  - Read/write pointers wrap modulo DEPTH.
- Latency: the cycle an accepted index completes a word is cycle N; row_valid (if the FIFO was empty) asserts at N+1. Registered outputs only; no combinational path from idx_* to row_*.
- Row spanning words: only the final word of a row carries row_last = 1. A row of exactly 4k indices produces k words, with no padded extra word.
- Backpressure: row_ready held low fills the FIFO to DEPTH, then idx_ready drops. Staging contents and the lane counter are preserved while stalled.
- Control FSM states:
  - EMPTY (lane counter == 0, staging clear).
  - FILLING (0 < lane counter < 4).
  - Transitions: EMPTY->FILLING on an accepted non-last index; FILLING->EMPTY on a word push.
  - An accepted index with idx_last in EMPTY stays in EMPTY and pushes a 1-index word.

Optional Feature:
- Macro ROW_PACKER_STATS_EN.
- When defined, add two outputs:
  - idx_count [31:0]: total indices accepted since reset, saturating at 32'hFFFFFFFF.
  - row_count [15:0]: number of words pushed with last = 1, wrapping modulo 2^16.
  - Both reset to 0 and update in the same cycle as the corresponding accept/push.
- When undefined, neither port nor counter exists, and the block behaves otherwise identically.

Test Plan:
- Reset, then indices 1,2,3,4 (last on 4), row_ready=1 -> one word 64'h0004_0003_0002_0001, row_last=1, row_valid one cycle after 4 is accepted.
- Indices 5,6,7 with last on 7 -> word 64'hFFFF_0007_0006_0005, row_last=1. Then flush with no index in EMPTY -> nothing pushed.
- 9-index row 0x10..0x18 (last on 0x18) -> three words: 0x0013_0012_0011_0010 (last=0), 0x0017_0016_0015_0014 (last=0), 0xFFFF_FFFF_FFFF_0018 (last=1).
- row_ready=0, stream 20 indices with DEPTH=4 -> idx_ready drops after 16 accepted. Raising row_ready drains words in order with no loss or duplication, and pointers wrap correctly.
- Indices 1,2 accepted, then reset asserted with 2 words in the FIFO -> next cycle row_valid=0, idx_ready=1. A following index 0xAA with last -> 64'hFFFF_FFFF_FFFF_00AA.
- With ROW_PACKER_STATS_EN: after the scenarios above, idx_count and row_count match the bench's counts of accepted indices and last-flagged pushes; a forced saturation check holds idx_count at 32'hFFFFFFFF.
